// File: rtl/booth_digit_decoder.sv
// booth_digit_decoder
// Sequential radix-4 Booth decoder/accumulator. Loads a signed multiplicand,
// then accepts one encoded Booth digit {sign, one, two} per handshake,
// least-significant digit first. Each digit becomes a partial product of
// 0, +/-A or +/-2A, which is added into the accumulator at weight 4^i.
// The 2*WIDTH signed product is presented with a valid/ready handshake.
module booth_digit_decoder #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [2:0]         digit,
  input  logic               digit_valid,
  output logic               digit_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic               prod_valid,
  input  logic               prod_ready,
  output logic               busy,
  output logic               err
);

  // Number of Booth digits is fixed by the operand width.
  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW     = WIDTH + 2;        // partial-product width
  localparam int AW     = 2 * WIDTH;        // accumulator / product width

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  a_reg;
  logic [AW-1:0]     acc;
  logic [CW-1:0]     count;
  logic              err_reg;
  logic [AW-1:0]     prod_reg;
  logic              prod_valid_reg;

  logic              accept;
  logic              last_digit;
  logic              illegal;
  logic [PW-1:0]     pp_mag;
  logic [PW-1:0]     pp;
  logic [AW-1:0]     pp_ext;
  logic [AW-1:0]     pp_shift;
  logic [AW-1:0]     acc_next;
  logic [CW:0]       shamt;

  // Handshake qualifiers derived from the current state.
  always_comb begin
    accept     = 1'b0;
    last_digit = 1'b0;
    if (state == ST_RUN) begin
      accept     = digit_valid;
      last_digit = (count == CW'(DIGITS - 1));
    end else begin
      accept     = 1'b0;
      last_digit = 1'b0;
    end
  end

  // Digit decode: magnitude 0/A/2A, then optional two's-complement negate.
  // One=two=1 is illegal and contributes nothing; a negated zero stays zero.
  always_comb begin
    illegal = digit[1] & digit[0];
    case (digit[1:0])
      2'b10:   pp_mag = {{2{a_reg[WIDTH-1]}}, a_reg};
      2'b01:   pp_mag = {a_reg[WIDTH-1], a_reg, 1'b0};
      default: pp_mag = {PW{1'b0}};
    endcase
    if (digit[2]) begin
      pp = ~pp_mag + PW'(1);
    end else begin
      pp = pp_mag;
    end
    pp_ext   = {{(AW - PW){pp[PW-1]}}, pp};
    shamt    = {count, 1'b0};
    pp_shift = pp_ext << shamt;
    acc_next = acc + pp_shift;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start outside IDLE is ignored.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept && last_digit) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_DONE: begin
        if (prod_ready) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs: digit_ready is live only in RUN.
  always_comb begin
    digit_ready = 1'b0;
    busy        = 1'b0;
    case (state)
      ST_RUN: begin
        digit_ready = 1'b1;
        busy        = 1'b1;
      end
      ST_DONE: begin
        digit_ready = 1'b0;
        busy        = 1'b1;
      end
      default: begin
        digit_ready = 1'b0;
        busy        = 1'b0;
      end
    endcase
  end

  // Datapath: operand load, digit accumulation, sticky error and the
  // registered product, which is loaded with the final sum as DONE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg          <= {WIDTH{1'b0}};
      acc            <= {AW{1'b0}};
      count          <= {CW{1'b0}};
      err_reg        <= 1'b0;
      prod_reg       <= {AW{1'b0}};
      prod_valid_reg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          prod_reg       <= {AW{1'b0}};
          prod_valid_reg <= 1'b0;
          if (start) begin
            a_reg   <= mcand;
            acc     <= {AW{1'b0}};
            count   <= {CW{1'b0}};
            err_reg <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            acc   <= acc_next;
            count <= count + CW'(1);
            if (illegal) begin
              err_reg <= 1'b1;
            end
            if (last_digit) begin
              prod_reg       <= acc_next;
              prod_valid_reg <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (prod_ready) begin
            prod_reg       <= {AW{1'b0}};
            prod_valid_reg <= 1'b0;
          end
        end
        default: begin
          prod_reg       <= {AW{1'b0}};
          prod_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign prod       = prod_reg;
  assign prod_valid = prod_valid_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_booth_digit_decoder.sv
// Directed self-checking bench for booth_digit_decoder (WIDTH=8).
module tb_booth_digit_decoder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  mcand;
  logic [2:0]  digit;
  logic        digit_valid;
  logic        digit_ready;
  logic [15:0] prod;
  logic        prod_valid;
  logic        prod_ready;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;
  logic [15:0] held_prod;

  booth_digit_decoder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mcand(mcand),
    .digit(digit), .digit_valid(digit_valid), .digit_ready(digit_ready),
    .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] m);
    start = 1'b1;
    mcand = m;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] d, input int gap);
    digit       = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    digit       = 3'b000;
    for (int g = 0; g < gap; g++) tick();
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (prod_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, prod_valid}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mcand = 8'd0; digit = 3'b000;
    digit_valid = 1'b0; prod_ready = 1'b1;
    #12;
    chk("rst_prod", {16'd0, prod}, 32'd0);
    chk("rst_pv", {31'd0, prod_valid}, 32'd0);
    chk("rst_dr", {31'd0, digit_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Test 1: 7 * 3
    do_start(8'd7);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_dr", {31'd0, digit_ready}, 32'd1);
    send(3'b110, 0);
    send(3'b010, 0);
    send(3'b000, 0);
    chk("t1_pv_early", {31'd0, prod_valid}, 32'd0);
    send(3'b000, 0);
    chk("t1_pv", {31'd0, prod_valid}, 32'd1);
    chk("t1_prod", {16'd0, prod}, 32'h0015);
    chk("t1_err", {31'd0, err}, 32'd0);
    chk("t1_dr_done", {31'd0, digit_ready}, 32'd0);
    tick();
    chk("t1_pv_idle", {31'd0, prod_valid}, 32'd0);
    chk("t1_prod_idle", {16'd0, prod}, 32'd0);
    chk("t1_busy_idle", {31'd0, busy}, 32'd0);

    // Test 2: -128 * -128
    do_start(8'h80);
    send(3'b000, 0);
    send(3'b000, 0);
    send(3'b000, 0);
    send(3'b101, 0);
    wait_valid("t2_pv");
    chk("t2_prod", {16'd0, prod}, 32'h4000);
    tick();

    // Test 3: negative-zero digits with gaps, 5 * 4
    do_start(8'd5);
    send(3'b100, 3);
    send(3'b010, 3);
    send(3'b100, 3);
    chk("t3_pv_early", {31'd0, prod_valid}, 32'd0);
    chk("t3_dr_gap", {31'd0, digit_ready}, 32'd1);
    send(3'b100, 0);
    wait_valid("t3_pv");
    chk("t3_prod", {16'd0, prod}, 32'd20);
    chk("t3_err", {31'd0, err}, 32'd0);
    tick();

    // Test 4: illegal digit, stale start in RUN, then backpressure
    prod_ready = 1'b0;
    do_start(8'd9);
    send(3'b111, 0);
    chk("t4_err_set", {31'd0, err}, 32'd1);
    do_start(8'd1);
    chk("t4_start_ign_busy", {31'd0, busy}, 32'd1);
    chk("t4_start_ign_dr", {31'd0, digit_ready}, 32'd1);
    send(3'b010, 0);
    send(3'b000, 0);
    send(3'b000, 0);
    wait_valid("t4_pv");
    chk("t4_prod", {16'd0, prod}, 32'd36);
    chk("t4_err", {31'd0, err}, 32'd1);
    held_prod = prod;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) start = 1'b1;
      else start = 1'b0;
      tick();
      chk("t5_hold_prod", {16'd0, prod}, {16'd0, held_prod});
      chk("t5_hold_pv", {31'd0, prod_valid}, 32'd1);
      chk("t5_hold_dr", {31'd0, digit_ready}, 32'd0);
    end
    start = 1'b0;
    prod_ready = 1'b1;
    tick();
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);
    chk("t5_idle_pv", {31'd0, prod_valid}, 32'd0);
    chk("t5_err_sticky", {31'd0, err}, 32'd1);

    // Test 6: next start clears err; reset mid-run aborts
    do_start(8'd7);
    chk("t6_err_clr", {31'd0, err}, 32'd0);
    send(3'b010, 0);
    send(3'b010, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_dr", {31'd0, digit_ready}, 32'd0);
    chk("t6_rst_pv", {31'd0, prod_valid}, 32'd0);
    chk("t6_rst_prod", {16'd0, prod}, 32'd0);
    chk("t6_rst_err", {31'd0, err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_start(8'd7);
    send(3'b110, 0);
    send(3'b010, 0);
    send(3'b000, 0);
    send(3'b000, 0);
    wait_valid("t6_pv");
    chk("t6_prod", {16'd0, prod}, 32'h0015);
    chk("t6_err", {31'd0, err}, 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
